vmem_term_ctrl: RTL

// Terminal write controller for the character video memory. Takes ASCII key events from the PS/2 path

---
 rtl/vmem_term_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vmem_term_ctrl.sv
// Terminal write controller for character video memory: cursor, wrap, ENTER/BS,
// full-screen and per-row clearing, circular-row scrolling via top_row.
module vmem_term_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int XW   = 7,
    parameter int YW   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         key_in,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic               clr_req,
    output logic               wr_en,
    output logic [XW+YW-1:0]   wr_addr,
    output logic [7:0]         wr_data,
    output logic [XW-1:0]      cur_x,
    output logic [YW-1:0]      cur_y,
    output logic [YW-1:0]      top_row,
    output logic               busy
);

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    state_t             r_state;
    logic [XW-1:0]      r_cx;
    logic [YW-1:0]      r_cy;
    logic [YW-1:0]      r_top;
    logic [XW-1:0]      r_clr_x;
    logic [YW-1:0]      r_clr_y;
    logic               r_wr_en;
    logic [XW+YW-1:0]   r_wr_addr;
    logic [7:0]         r_wr_data;

    logic               w_accept;
    logic               w_print;
    logic               w_adv;
    logic [YW-1:0]      w_ny;

    assign key_ready = (r_state == IDLE) && !clr_req;
    assign w_accept  = key_valid && key_ready;
    assign w_print   = (key_in >= 8'h20) && (key_in <= 8'h7E);
    assign w_ny      = (r_cy == Y_LAST) ? '0 : r_cy + 1'b1;
    // Row advance comes from ENTER or from a printable key landing in the last column
    assign w_adv     = w_accept && ((key_in == 8'h0A) || (w_print && (r_cx == X_LAST)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CLR_ALL;
            r_cx      <= '0;
            r_cy      <= '0;
            r_top     <= '0;
            r_clr_x   <= '0;
            r_clr_y   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                CLR_ALL: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= {r_clr_x, r_clr_y};
                    r_wr_data <= '0;
                    if (r_clr_x == X_LAST) begin
                        r_clr_x <= '0;
                        if (r_clr_y == Y_LAST) begin
                            r_clr_y <= '0;
                            r_cx    <= '0;
                            r_cy    <= '0;
                            r_top   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_clr_y <= r_clr_y + 1'b1;
                        end
                    end else begin
                        r_clr_x <= r_clr_x + 1'b1;
                    end
                end
                CLR_ROW: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= {r_clr_x, r_clr_y};
                    r_wr_data <= '0;
                    if (r_clr_x == X_LAST) begin
                        r_clr_x <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_clr_x <= r_clr_x + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        r_clr_x <= '0;
                        r_clr_y <= '0;
                        r_state <= CLR_ALL;
                    end else if (w_accept) begin
                        if (w_print) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= {r_cx, r_cy};
                            r_wr_data <= key_in;
                            if (r_cx != X_LAST)
                                r_cx <= r_cx + 1'b1;
                        end else if ((key_in == 8'h08) && (r_cx != '0)) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= {r_cx - 1'b1, r_cy};
                            r_wr_data <= '0;
                            r_cx      <= r_cx - 1'b1;
                        end
                        // The character write above still happens; only the cursor is overridden
                        if (w_adv) begin
                            r_cx    <= '0;
                            r_cy    <= w_ny;
                            r_clr_x <= '0;
                            r_clr_y <= w_ny;
                            r_state <= CLR_ROW;
                            if (w_ny == r_top)
                                r_top <= (r_top == Y_LAST) ? '0 : r_top + 1'b1;
                        end
                    end
                end
                default: r_state <= CLR_ALL;
            endcase
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign cur_x   = r_cx;
    assign cur_y   = r_cy;
    assign top_row = r_top;
    assign busy    = (r_state != IDLE);

endmodule
